// File: rtl/irq_ctrl.sv
// irq_ctrl: trap/interrupt sequencer driving CSR trap strobes, PC redirect and flush
module irq_ctrl #(
  parameter int XLEN = 32,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [31:0]     mip,
  input  logic [31:0]     mie,
  input  logic            mie_global,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic            commit_valid,
  input  logic            ecall_exc,
  input  logic            illegal_exc,
  input  logic            mret_on,
  output logic            int_action,
  output logic            ret_action,
  output logic            hw_int,
  output logic [4:0]      int_code,
  output logic [1:0]      pc_sel,
  output logic [XLEN-1:0] trap_pc,
  output logic            flush
);
  typedef enum logic [1:0] {IDLE, TRAP, RET, HOLD} state_t;
  state_t state_q, state_d;
  logic hw_int_q, hw_int_d;
  logic [4:0] int_code_q, int_code_d;
  logic [XLEN-1:0] trap_pc_q, trap_pc_d, base;
  logic [31:0] irq_vec;
  logic irq_hit, exc_hit, vec_mode, unused_ok;
  always_comb begin
    irq_vec = mip & mie & {32{mie_global}};
    irq_hit = irq_vec[11] | irq_vec[3] | irq_vec[7];
    exc_hit = illegal_exc | ecall_exc;
    base = {mtvec[XLEN-1:2], 2'b00};
    vec_mode = VECTORED_EN && mtvec[1:0] == 2'b01;
    state_d = IDLE;
    hw_int_d = hw_int_q;
    int_code_d = int_code_q;
    trap_pc_d = trap_pc_q;
    if (state_q == IDLE && commit_valid) begin
      if (irq_hit) begin
        state_d = TRAP;
        hw_int_d = 1'b1;
        int_code_d = irq_vec[11] ? 5'd11 : irq_vec[3] ? 5'd3 : 5'd7;
      end else if (exc_hit) begin
        state_d = TRAP;
        hw_int_d = 1'b0;
        int_code_d = illegal_exc ? 5'd2 : 5'd11;
      end else if (mret_on) begin
        state_d = RET;
      end
      // target is frozen here so mtvec writes during TRAP cannot move it
      if (state_d == TRAP)
        trap_pc_d = (hw_int_d && vec_mode) ? base + XLEN'({int_code_d, 2'b00}) : base;
    end else begin
      state_d = (state_q == TRAP || state_q == RET) ? HOLD : IDLE;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hw_int_q <= 1'b0;
      int_code_q <= 5'd0;
      trap_pc_q <= '0;
    end else begin
      state_q <= state_d;
      hw_int_q <= hw_int_d;
      int_code_q <= int_code_d;
      trap_pc_q <= trap_pc_d;
    end
  end
  assign int_action = state_q == TRAP;
  assign ret_action = state_q == RET;
  assign flush = int_action | ret_action;
  assign pc_sel = {ret_action, int_action};
  assign hw_int = hw_int_q;
  assign int_code = int_code_q;
  assign trap_pc = trap_pc_q;
  assign unused_ok = ^{mip, mie, mepc, mtvec[1:0]};
endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: scenario tasks with a scoreboard of expected registered outputs
module tb_irq_ctrl;
  logic clk, reset_n;
  logic [31:0] mip, mie, mtvec, mepc;
  logic mie_global, commit_valid, ecall_exc, illegal_exc, mret_on;
  logic int_action, ret_action, hw_int, flush;
  logic [4:0] int_code;
  logic [1:0] pc_sel;
  logic [31:0] trap_pc;
  logic int_action_0, ret_action_0, hw_int_0, flush_0;
  logic [4:0] int_code_0;
  logic [1:0] pc_sel_0;
  logic [31:0] trap_pc_0;
  int tests = 0, fails = 0;

  typedef struct packed {
    logic [4:0] st;
    logic hw;
    logic [4:0] code;
    logic [31:0] pc, pc0;
  } obs_t;
  typedef struct packed {
    logic [31:0] mip, mie;
    logic g;
    logic [31:0] tv;
    logic cv, ec, il, mr;
    obs_t e;
  } step_t;

  localparam logic [4:0] S_T = 5'b10011, S_R = 5'b01101, S_N = 5'b00000;

  obs_t sb[$];

  irq_ctrl #(.XLEN(32), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .mip(mip), .mie(mie), .mie_global(mie_global),
    .mtvec(mtvec), .mepc(mepc), .commit_valid(commit_valid), .ecall_exc(ecall_exc),
    .illegal_exc(illegal_exc), .mret_on(mret_on), .int_action(int_action),
    .ret_action(ret_action), .hw_int(hw_int), .int_code(int_code), .pc_sel(pc_sel),
    .trap_pc(trap_pc), .flush(flush));

  irq_ctrl #(.XLEN(32), .VECTORED_EN(1'b0)) dut0 (
    .clk(clk), .reset_n(reset_n), .mip(mip), .mie(mie), .mie_global(mie_global),
    .mtvec(mtvec), .mepc(mepc), .commit_valid(commit_valid), .ecall_exc(ecall_exc),
    .illegal_exc(illegal_exc), .mret_on(mret_on), .int_action(int_action_0),
    .ret_action(ret_action_0), .hw_int(hw_int_0), .int_code(int_code_0), .pc_sel(pc_sel_0),
    .trap_pc(trap_pc_0), .flush(flush_0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic step_t mk(logic [31:0] p, logic [31:0] en, logic g, logic [31:0] tv,
                               logic cv, logic ec, logic il, logic mr, logic [4:0] st,
                               logic hw, logic [4:0] code, logic [31:0] pc, logic [31:0] pc0);
    step_t s;
    s.mip = p; s.mie = en; s.g = g; s.tv = tv;
    s.cv = cv; s.ec = ec; s.il = il; s.mr = mr;
    s.e.st = st; s.e.hw = hw; s.e.code = code; s.e.pc = pc; s.e.pc0 = pc0;
    return s;
  endfunction

  function automatic step_t idle_step();
    return mk(0, 0, 0, 32'h1000, 0, 0, 0, 0, S_N, 0, 0, 0, 0);
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = {int_action, ret_action, pc_sel, flush};
    o.hw = hw_int; o.code = int_code; o.pc = trap_pc; o.pc0 = trap_pc_0;
    return o;
  endfunction

  task automatic drive(input step_t s);
    mip = s.mip; mie = s.mie; mie_global = s.g; mtvec = s.tv; mepc = 32'h400;
    commit_valid = s.cv; ecall_exc = s.ec; illegal_exc = s.il; mret_on = s.mr;
    sb.push_back(s.e);
  endtask

  task automatic test_reset();
    drive(idle_step());
    sb.delete();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({int_action, ret_action, hw_int, flush, int_code, pc_sel, trap_pc, trap_pc_0} !== '0) begin
      fails++;
      $display("FAIL reset: got ia=%b ra=%b hw=%b fl=%b code=%0d sel=%b pc=%h pc0=%h, need all zero",
               int_action, ret_action, hw_int, flush, int_code, pc_sel, trap_pc, trap_pc_0);
    end
    reset_n = 1'b1;
  endtask

  task automatic test_timer();
    step_t s[3];
    obs_t e, g;
    s[0] = mk(32'h80, 32'h80, 1, 32'h1000, 1, 0, 0, 0, S_T, 1, 7, 32'h1000, 32'h1000);
    s[1] = idle_step();
    s[2] = idle_step();
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = sb.pop_front(); g = sample(); tests++;
      if (g.st !== e.st || (e.st[4] && {g.hw, g.code, g.pc, g.pc0} !== {e.hw, e.code, e.pc, e.pc0})) begin
        fails++;
        $display("FAIL timer[%0d]: got st=%b hw=%b code=%0d pc=%h pc0=%h need st=%b hw=%b code=%0d pc=%h pc0=%h",
                 i, g.st, g.hw, g.code, g.pc, g.pc0, e.st, e.hw, e.code, e.pc, e.pc0);
      end
    end
  endtask

  task automatic test_priority();
    step_t s[3];
    obs_t e, g;
    s[0] = mk(32'h888, 32'h888, 1, 32'h2001, 1, 0, 0, 0, S_T, 1, 11, 32'h202C, 32'h2000);
    s[1] = idle_step();
    s[2] = idle_step();
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = sb.pop_front(); g = sample(); tests++;
      if (g.st !== e.st || (e.st[4] && {g.hw, g.code, g.pc, g.pc0} !== {e.hw, e.code, e.pc, e.pc0})) begin
        fails++;
        $display("FAIL priority[%0d]: got st=%b hw=%b code=%0d pc=%h pc0=%h need st=%b hw=%b code=%0d pc=%h pc0=%h",
                 i, g.st, g.hw, g.code, g.pc, g.pc0, e.st, e.hw, e.code, e.pc, e.pc0);
      end
    end
  endtask

  task automatic test_masking();
    step_t s[7];
    obs_t e, g;
    s[0] = mk(32'h8, 32'h8, 0, 32'h1000, 1, 0, 0, 0, S_N, 0, 0, 0, 0);
    s[1] = mk(32'h8, 32'h8, 1, 32'h1000, 0, 0, 0, 0, S_N, 0, 0, 0, 0);
    s[2] = s[1];
    s[3] = s[1];
    s[4] = mk(32'h8, 32'h8, 1, 32'h1000, 1, 0, 0, 0, S_T, 1, 3, 32'h1000, 32'h1000);
    s[5] = mk(32'h8, 32'h8, 0, 32'h1000, 0, 0, 0, 0, S_N, 0, 0, 0, 0);
    s[6] = s[5];
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = sb.pop_front(); g = sample(); tests++;
      if (g.st !== e.st || (e.st[4] && {g.hw, g.code, g.pc, g.pc0} !== {e.hw, e.code, e.pc, e.pc0})) begin
        fails++;
        $display("FAIL masking[%0d]: got st=%b hw=%b code=%0d pc=%h pc0=%h need st=%b hw=%b code=%0d pc=%h pc0=%h",
                 i, g.st, g.hw, g.code, g.pc, g.pc0, e.st, e.hw, e.code, e.pc, e.pc0);
      end
    end
  endtask

  task automatic test_exceptions();
    step_t s[6];
    obs_t e, g;
    s[0] = mk(0, 0, 1, 32'h2001, 1, 1, 1, 0, S_T, 0, 2, 32'h2000, 32'h2000);
    s[1] = idle_step();
    s[2] = idle_step();
    s[3] = mk(0, 0, 1, 32'h2001, 1, 1, 0, 0, S_T, 0, 11, 32'h2000, 32'h2000);
    s[4] = idle_step();
    s[5] = idle_step();
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = sb.pop_front(); g = sample(); tests++;
      if (g.st !== e.st || (e.st[4] && {g.hw, g.code, g.pc, g.pc0} !== {e.hw, e.code, e.pc, e.pc0})) begin
        fails++;
        $display("FAIL exceptions[%0d]: got st=%b hw=%b code=%0d pc=%h pc0=%h need st=%b hw=%b code=%0d pc=%h pc0=%h",
                 i, g.st, g.hw, g.code, g.pc, g.pc0, e.st, e.hw, e.code, e.pc, e.pc0);
      end
    end
  endtask

  task automatic test_mret();
    step_t s[6];
    obs_t e, g;
    s[0] = mk(0, 0, 1, 32'h1000, 1, 0, 0, 1, S_R, 0, 0, 0, 0);
    s[1] = idle_step();
    s[2] = idle_step();
    s[3] = mk(32'h800, 32'h800, 1, 32'h1000, 1, 0, 0, 1, S_T, 1, 11, 32'h1000, 32'h1000);
    s[4] = idle_step();
    s[5] = idle_step();
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = sb.pop_front(); g = sample(); tests++;
      if (g.st !== e.st || (e.st[4] && {g.hw, g.code, g.pc, g.pc0} !== {e.hw, e.code, e.pc, e.pc0})) begin
        fails++;
        $display("FAIL mret[%0d]: got st=%b hw=%b code=%0d pc=%h pc0=%h need st=%b hw=%b code=%0d pc=%h pc0=%h",
                 i, g.st, g.hw, g.code, g.pc, g.pc0, e.st, e.hw, e.code, e.pc, e.pc0);
      end
    end
  endtask

  task automatic test_back_to_back();
    step_t s[7];
    obs_t e, g;
    for (int i = 0; i < 6; i++)
      s[i] = mk(32'h80, 32'h80, 1, 32'h3001, 1, 0, 0, 0, (i % 3 == 0) ? S_T : S_N, 1, 7, 32'h301C, 32'h3000);
    s[6] = idle_step();
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = sb.pop_front(); g = sample(); tests++;
      if (g.st !== e.st || (e.st[4] && {g.hw, g.code, g.pc, g.pc0} !== {e.hw, e.code, e.pc, e.pc0})) begin
        fails++;
        $display("FAIL back_to_back[%0d]: got st=%b hw=%b code=%0d pc=%h pc0=%h need st=%b hw=%b code=%0d pc=%h pc0=%h",
                 i, g.st, g.hw, g.code, g.pc, g.pc0, e.st, e.hw, e.code, e.pc, e.pc0);
      end
    end
  endtask

  task automatic test_reset_mid_trap();
    step_t s[3];
    obs_t e, g;
    drive(mk(32'h80, 32'h80, 1, 32'h1000, 1, 0, 0, 0, S_T, 1, 7, 32'h1000, 32'h1000));
    @(negedge clk);
    e = sb.pop_front(); g = sample(); tests++;
    if (g.st !== e.st) begin
      fails++;
      $display("FAIL mid_trap_entry: got st=%b need st=%b", g.st, e.st);
    end
    #2 reset_n = 1'b0;
    #1 tests++;
    if ({int_action, flush, pc_sel} !== 4'b0000) begin
      fails++;
      $display("FAIL mid_trap_abort: got ia=%b fl=%b sel=%b need 0 0 00", int_action, flush, pc_sel);
    end
    @(negedge clk);
    reset_n = 1'b1;
    foreach (s[i]) s[i] = idle_step();
    foreach (s[i]) begin
      drive(s[i]);
      @(negedge clk);
      e = sb.pop_front(); g = sample(); tests++;
      if (g.st !== e.st) begin
        fails++;
        $display("FAIL post_reset_idle[%0d]: got st=%b need st=%b", i, g.st, e.st);
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    test_reset();
    test_timer();
    test_priority();
    test_masking();
    test_exceptions();
    test_mret();
    test_back_to_back();
    test_reset_mid_trap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
